fpmul_stim_gen: RTL and testbench

- Synthesizable, parametrised stimulus generator; next generation of the data_maker used in the FPmul benches.
- Drives independent A/B operands (no longer the same value on both multiplier inputs) with selectable pattern modes, a programmable sample count and a pipeline-aligned valid flag.
- Raises END_SIM only after the DUT pipeline has drained.
- Sits between clk_gen and the multiplier UUT; also reusable on-chip as a BIST source.

---
 rtl/fpmul_stim_pkg.sv | 73 +++++++
 rtl/fpmul_stim_gen_lfsr.sv | 44 ++++
 rtl/fpmul_stim_gen.sv | 179 +++++++++++++++++
 tb/tb_fpmul_stim_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fpmul_stim_pkg.sv
// ============================================================================
// Module      : fpmul_stim_pkg
// Description : Shared types and constants for the fpmul_stim_gen stimulus
//               generator: FSM state enum, pattern-mode encodings, Galois LFSR
//               tap masks, IEEE-754 special-value table and the sample-counter
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpmul_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } stim_state_e;

  localparam logic [1:0] MODE_COUNTER = 2'd0;
  localparam logic [1:0] MODE_LFSR    = 2'd1;
  localparam logic [1:0] MODE_WALK    = 2'd2;
  localparam logic [1:0] MODE_ALT     = 2'd3;

  // Right-shifting Galois masks: bit (e-1) set for every polynomial term x^e.
  localparam logic [63:0] LFSR_TAPS_16 = 64'h0000_0000_0000_B400; // x^16+x^14+x^13+x^11+1
  localparam logic [63:0] LFSR_TAPS_32 = 64'h0000_0000_8020_0003; // x^32+x^22+x^2+x+1
  localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000; // x^64+x^63+x^61+x^60+1

  function automatic logic [63:0] lfsr_taps(input int w);
    case (w)
      16:      return LFSR_TAPS_16;
      64:      return LFSR_TAPS_64;
      default: return LFSR_TAPS_32;
    endcase
  endfunction

  // Special pairs, cycled per occurrence:
  //   0: (+0, +inf)  1: (NaN, 1.0)  2: (-inf, min denormal)  3: (max normal, 2.0)
  function automatic logic [63:0] special_val(input int w, input logic [1:0] idx, input logic sel_b);
    logic [63:0] v;
    v = '0;
    case (w)
      16: case ({idx, sel_b})
            3'b000: v = 64'h0000;  3'b001: v = 64'h7C00;
            3'b010: v = 64'h7E00;  3'b011: v = 64'h3C00;
            3'b100: v = 64'hFC00;  3'b101: v = 64'h0001;
            3'b110: v = 64'h7BFF;  default: v = 64'h4000;
          endcase
      64: case ({idx, sel_b})
            3'b000: v = 64'h0000_0000_0000_0000;  3'b001: v = 64'h7FF0_0000_0000_0000;
            3'b010: v = 64'h7FF8_0000_0000_0000;  3'b011: v = 64'h3FF0_0000_0000_0000;
            3'b100: v = 64'hFFF0_0000_0000_0000;  3'b101: v = 64'h0000_0000_0000_0001;
            3'b110: v = 64'h7FEF_FFFF_FFFF_FFFF;  default: v = 64'h4000_0000_0000_0000;
          endcase
      default: case ({idx, sel_b})
            3'b000: v = 64'h0000_0000;  3'b001: v = 64'h7F80_0000;
            3'b010: v = 64'h7FC0_0000;  3'b011: v = 64'h3F80_0000;
            3'b100: v = 64'hFF80_0000;  3'b101: v = 64'h0000_0001;
            3'b110: v = 64'h7F7F_FFFF;  default: v = 64'h4000_0000;
          endcase
    endcase
    return v;
  endfunction

  // Counter wide enough to hold N_SAMPLES itself (terminal count + 1).
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpmul_stim_gen_lfsr.sv
// ============================================================================
// Module      : stim_lfsr
// Description : Right-shifting Galois LFSR, one step per cycle with step=1.
//               Polynomial selected from DATA_W; resets to SEED.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stim_lfsr
  import fpmul_stim_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] SEED   = '1
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              step,
  output logic [DATA_W-1:0] q
);

  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

  logic [DATA_W-1:0] lfsr_q;
  logic [DATA_W-1:0] lfsr_d;

  // Next value: shift right, fold the taps back in when a one falls out.
  always_comb begin
    lfsr_d = lfsr_q;
    if (step) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  // State register, reloaded with SEED on reset.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/fpmul_stim_gen.sv
// ============================================================================
// Module      : fpmul_stim_gen
// Description : Stimulus generator for FP multiplier benches / BIST. Emits
//               N_SAMPLES independent A/B operand pairs in one of four pattern
//               modes, a LATENCY-delayed valid aligned with the DUT output, and
//               END_SIM once the DUT pipeline has drained.
//               Optional macro STIM_SPECIAL_EN: every sample with k mod 16 == 15
//               is replaced by an IEEE-754 special pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpmul_stim_gen
  import fpmul_stim_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          N_SAMPLES = 256,
  parameter int          LATENCY   = 4,
  parameter logic [63:0] SEED      = 64'h0000_0000_1ACE_B00C,
  localparam int         CNT_W     = cnt_width(N_SAMPLES)
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              START,
  input  logic              DATA_EN,
  input  logic [1:0]        MODE,
  output logic [DATA_W-1:0] DATA_A,
  output logic [DATA_W-1:0] DATA_B,
  output logic              VOUT,
  output logic              VOUT_DLY,
  output logic [CNT_W-1:0]  SAMPLE_IDX,
  output logic              BUSY,
  output logic              END_SIM
);

  localparam int                DRAIN_W = $clog2(LATENCY + 1) + 1;
  localparam logic [DATA_W-1:0] SEED_W  = SEED[DATA_W-1:0];

  stim_state_e         state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [CNT_W-1:0]    k_q, k_d;
  logic [DATA_W-1:0]   data_a_q, data_a_d;
  logic [DATA_W-1:0]   data_b_q, data_b_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic                vout_q, vout_d;
  logic [LATENCY-1:0]  dly_q, dly_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;

  logic                emit;
  logic                lfsr_step;
  logic [DATA_W-1:0]   lfsr_a, lfsr_b;
  logic [DATA_W-1:0]   pat_a, pat_b;
  logic [31:0]         k32;

  assign emit      = (state_q == ST_RUN) && DATA_EN;
  assign lfsr_step = emit && (mode_q == MODE_LFSR);
  assign k32       = 32'(k_q);

  // The LFSR value presented with sample k is the state before its step,
  // so sample 0 carries SEED (A) and ~SEED (B).
  stim_lfsr #(.DATA_W(DATA_W), .SEED(SEED_W)) u_lfsr_a (
    .CLK   (CLK),
    .RST_n (RST_n),
    .step  (lfsr_step),
    .q     (lfsr_a)
  );

  stim_lfsr #(.DATA_W(DATA_W), .SEED(~SEED_W)) u_lfsr_b (
    .CLK   (CLK),
    .RST_n (RST_n),
    .step  (lfsr_step),
    .q     (lfsr_b)
  );

  // Operand pair for the sample index currently held in k_q.
  always_comb begin
    pat_a = '0;
    pat_b = '0;
    case (mode_q)
      MODE_COUNTER: begin
        pat_a = DATA_W'(k_q);
        pat_b = DATA_W'(k_q) + DATA_W'(1);
      end
      MODE_LFSR: begin
        pat_a = lfsr_a;
        pat_b = lfsr_b;
      end
      MODE_WALK: begin
        pat_a = DATA_W'(1) << (k32 % DATA_W);
        pat_b = '1;
      end
      default: begin
        pat_a = k_q[0] ? ~SEED_W : SEED_W;
        pat_b = k_q[0] ? SEED_W  : ~SEED_W;
      end
    endcase
`ifdef STIM_SPECIAL_EN
    // Pattern state keeps advancing underneath; only the emitted pair changes.
    if (k32[3:0] == 4'hF) begin
      pat_a = DATA_W'(special_val(DATA_W, k32[5:4], 1'b0));
      pat_b = DATA_W'(special_val(DATA_W, k32[5:4], 1'b1));
    end
`endif
  end

  // Next-state and datapath updates; everything holds unless the state acts.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    k_d      = k_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    idx_d    = idx_q;
    vout_d   = 1'b0;
    drain_d  = drain_q;
    dly_d    = (dly_q << 1) | LATENCY'(vout_q);
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_RUN;
          mode_d  = MODE;
        end
      end
      ST_RUN: begin
        if (DATA_EN) begin
          data_a_d = pat_a;
          data_b_d = pat_b;
          idx_d    = k_q;
          vout_d   = 1'b1;
          k_d      = k_q + CNT_W'(1);
          if (k_q == CNT_W'(N_SAMPLES - 1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Last VOUT enters the delay line on the first DRAIN edge and leaves
        // LATENCY edges later; DONE follows on the next edge.
        if (drain_q == DRAIN_W'(LATENCY)) state_d = ST_DONE;
        else                              drain_d = drain_q + DRAIN_W'(1);
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset aborts any run immediately.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_COUNTER;
      k_q      <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      idx_q    <= '0;
      vout_q   <= 1'b0;
      dly_q    <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      k_q      <= k_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      idx_q    <= idx_d;
      vout_q   <= vout_d;
      dly_q    <= dly_d;
      drain_q  <= drain_d;
    end
  end

  assign DATA_A     = data_a_q;
  assign DATA_B     = data_b_q;
  assign VOUT       = vout_q;
  assign VOUT_DLY   = dly_q[LATENCY-1];
  assign SAMPLE_IDX = idx_q;
  assign BUSY       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign END_SIM    = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_fpmul_stim_gen.sv
// ============================================================================
// Module      : tb_fpmul_stim_gen
// Description : Self-checking bench for fpmul_stim_gen (DATA_W=32, 40 samples,
//               LATENCY=4). Honours STIM_SPECIAL_EN in its reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpmul_stim_gen;

  localparam int          DW    = 32;
  localparam int          N     = 40;
  localparam int          LAT   = 4;
  localparam int          CNT_W = $clog2(N) + 1;
  localparam logic [31:0] SEED  = 32'h1ACE_B00C;

  logic             CLK = 1'b0;
  logic             RST_n;
  logic             START;
  logic             DATA_EN;
  logic [1:0]       MODE;
  logic [DW-1:0]    DATA_A, DATA_B;
  logic             VOUT, VOUT_DLY, BUSY, END_SIM;
  logic [CNT_W-1:0] SAMPLE_IDX;

  int checks   = 0;
  int failures = 0;

  logic [31:0] lfa [N];
  logic [31:0] lfb [N];

  fpmul_stim_gen #(
    .DATA_W    (DW),
    .N_SAMPLES (N),
    .LATENCY   (LAT),
    .SEED      (64'(SEED))
  ) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .START      (START),
    .DATA_EN    (DATA_EN),
    .MODE       (MODE),
    .DATA_A     (DATA_A),
    .DATA_B     (DATA_B),
    .VOUT       (VOUT),
    .VOUT_DLY   (VOUT_DLY),
    .SAMPLE_IDX (SAMPLE_IDX),
    .BUSY       (BUSY),
    .END_SIM    (END_SIM)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One step of x^32+x^22+x^2+x+1 in right-shifting Galois form.
  function automatic logic [31:0] galois_next(input logic [31:0] x);
    logic [31:0] poly;
    int          ex [3] = '{22, 2, 1};
    poly     = '0;
    poly[31] = 1'b1;
    foreach (ex[j]) poly[ex[j]-1] = 1'b1;
    return x[0] ? ((x >> 1) ^ poly) : (x >> 1);
  endfunction

  // Reference operand for sample k; sel_b picks operand B.
  function automatic logic [31:0] ref_pat(input logic [1:0] mode, input int k, input bit sel_b);
    logic [31:0] a, b;
    case (mode)
      2'd0:    begin a = 32'(k);            b = 32'(k + 1);    end
      2'd1:    begin a = lfa[k];            b = lfb[k];        end
      2'd2:    begin a = 32'h1 << (k % 32); b = 32'hFFFF_FFFF; end
      default: begin
        a = (k % 2 == 0) ? SEED : ~SEED;
        b = (k % 2 == 0) ? ~SEED : SEED;
      end
    endcase
`ifdef STIM_SPECIAL_EN
    if (k % 16 == 15) begin
      case ((k / 16) % 4)
        0:       begin a = 32'h0000_0000; b = 32'h7F80_0000; end
        1:       begin a = 32'h7FC0_0000; b = 32'h3F80_0000; end
        2:       begin a = 32'hFF80_0000; b = 32'h0000_0001; end
        default: begin a = 32'h7F7F_FFFF; b = 32'h4000_0000; end
      endcase
    end
`endif
    return sel_b ? b : a;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_a"},     64'(DATA_A),     64'h0);
    chk({tag, "_b"},     64'(DATA_B),     64'h0);
    chk({tag, "_idx"},   64'(SAMPLE_IDX), 64'h0);
    chk({tag, "_vout"},  64'(VOUT),       64'h0);
    chk({tag, "_dly"},   64'(VOUT_DLY),   64'h0);
    chk({tag, "_busy"},  64'(BUSY),       64'h0);
    chk({tag, "_end"},   64'(END_SIM),    64'h0);
  endtask

  task automatic do_reset();
    RST_n = 1'b0; START = 1'b0; DATA_EN = 1'b0; MODE = 2'd0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST_n = 1'b1;
  endtask

  // One run: en_kind 100 = always enabled, <0 = pattern 1,0,0, else percent.
  // noise toggles START/MODE after the start edge; abort_k >= 0 drops reset
  // right after sample abort_k has been emitted.
  task automatic run(input logic [1:0] mode, input int en_kind, input bit noise, input int abort_k);
    int          k, last, n_vout, n_dly, post;
    bit          hist [$];
    bit          en, emit, edly, eend;
    logic [31:0] ea, eb;
    int          ei;
    k = 0; last = -1; n_vout = 0; n_dly = 0; post = 0;
    ea = '0; eb = '0; ei = 0; eend = 1'b0;
    for (int i = 0; i < 20 * N + 100; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        START = 1'b1; MODE = mode;
      end else begin
        START = (noise || eend) ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (noise) MODE = 2'($urandom);
      end
      if (en_kind == 100)   en = 1'b1;
      else if (en_kind < 0) en = (i % 3 == 1);
      else                  en = ($urandom_range(0, 99) < en_kind);
      DATA_EN = en;
      @(posedge CLK); #1;
      emit = (i >= 1) && (k < N) && en;
      if (emit) begin
        ea = ref_pat(mode, k, 1'b0);
        eb = ref_pat(mode, k, 1'b1);
        ei = k;
        k++;
        if (k == N) last = i;
      end
      hist.push_back(emit);
      edly = (i >= LAT) ? hist[i - LAT] : 1'b0;
      eend = (last >= 0) && (i >= last + LAT + 1);
      chk("vout",     64'(VOUT),       64'(emit));
      chk("data_a",   64'(DATA_A),     64'(ea));
      chk("data_b",   64'(DATA_B),     64'(eb));
      chk("idx",      64'(SAMPLE_IDX), 64'(ei));
      chk("vout_dly", 64'(VOUT_DLY),   64'(edly));
      chk("busy",     64'(BUSY),       64'(!eend));
      chk("end_sim",  64'(END_SIM),    64'(eend));
      if (emit && mode == 2'd1) chk("lfsr_b_ne_a", 64'(DATA_A !== DATA_B), 64'h1);
      n_vout += int'(VOUT);
      n_dly  += int'(VOUT_DLY);
      if (abort_k >= 0 && k == abort_k + 1) begin
        #2 RST_n = 1'b0;
        #1 check_all_zero("abort");
        @(negedge CLK);
        RST_n = 1'b1; START = 1'b0;
        @(posedge CLK); #1;
        chk("post_abort_busy", 64'(BUSY),    64'h0);
        chk("post_abort_end",  64'(END_SIM), 64'h0);
        return;
      end
      if (eend) begin
        post++;
        if (post == 4) break;
      end
    end
    chk("vout_count",     64'(n_vout), 64'(N));
    chk("vout_dly_count", 64'(n_dly),  64'(N));
  endtask

  initial begin
    RST_n = 1'b0; START = 1'b0; DATA_EN = 1'b0; MODE = 2'd0;
    lfa[0] = SEED;
    lfb[0] = ~SEED;
    for (int j = 1; j < N; j++) begin
      lfa[j] = galois_next(lfa[j-1]);
      lfb[j] = galois_next(lfb[j-1]);
    end

    do_reset(); run(2'd0, 100, 1'b0, -1);   // counter, continuous enable
    do_reset(); run(2'd1,  70, 1'b0, -1);   // LFSR, random bubbles
    do_reset(); run(2'd2,  -1, 1'b0, -1);   // walking one, 1,0,0 enable pattern
    do_reset(); run(2'd1,  80, 1'b0,  3);   // abort after sample 3
    run(2'd1, 75, 1'b1, -1);                // restart from k=0 with START/MODE noise
    do_reset(); run(2'd3,  60, 1'b1, -1);   // alternating, noise

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
